// File: rtl/dmgplus_vram_pkg.sv
// Shared VRAM arbiter types: address/pixel widths, the buffered write entry and the slot choice.
package dmgplus_vram_pkg;
   localparam int VRAM_AW = 16;
   localparam int PIX_W   = 2;

   typedef struct packed {
      logic [VRAM_AW-1:0] addr;
      logic [PIX_W-1:0]   data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,
      SLOT_READ  = 2'd1,
      SLOT_WRITE = 2'd2
   } slot_e;
endpackage

// File: rtl/vram_wr_fifo.sv
// Sampler write buffer: registered push/pop, head visible combinationally, flush clears it in one cycle.
// No backpressure: a push into a full FIFO is discarded unless a pop frees the slot in the same cycle.
module vram_wr_fifo
   import dmgplus_vram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   flush,
   input  logic                   push,
   input  wr_entry_t              push_dat,
   input  logic                   pop,
   output wr_entry_t              head_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   wr_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          push_ok, pop_ok;

   assign full     = (level_q == FULL_LVL);
   assign empty    = (level_q == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign head_dat = mem_q[rd_ptr_q];
   assign level    = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= push_dat;
   end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: reads win, buffered sampler writes get a forced slot after MAX_WAIT-1 waits.
// Read grant to rd_valid is 2 cycles; writes have no backpressure and overflow drops are counted.
module vram_arbiter
   import dmgplus_vram_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic                        vramclk,
   input  logic                        rst,
   input  logic                        wr_we,
   input  logic [VRAM_AW-1:0]          wr_addr,
   input  logic [PIX_W-1:0]            wr_data,
   input  logic                        rd_req,
   input  logic [VRAM_AW-1:0]          rd_addr,
   output logic                        rd_gnt,
   output logic                        rd_valid,
   output logic [PIX_W-1:0]            rd_data,
   output logic [VRAM_AW-1:0]          mem_addr,
   output logic [PIX_W-1:0]            mem_wdata,
   output logic                        mem_we,
   output logic                        mem_re,
   input  logic [PIX_W-1:0]            mem_rdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic [7:0]                  drop_count
);
   localparam int            WW        = $clog2(MAX_WAIT) + 1;
   localparam int            WL        = MAX_WAIT - 1;
   localparam logic [WW-1:0] WAIT_LAST = WL[WW-1:0];

   slot_e              slot;
   wr_entry_t          head_dat;
   logic               fifo_full, fifo_empty, push, pop, drop;
   logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
   logic [VRAM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [PIX_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic               mem_we_q, mem_we_d, mem_re_q, mem_re_d;
   logic               rd_valid_q, rd_valid_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         drop_count_q, drop_count_d;

   assign push = wr_we && !rst;
   assign pop  = (slot == SLOT_WRITE);
   assign drop = push && fifo_full && !pop;

   vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clk      (vramclk),
      .flush    (rst),
      .push     (push),
      .push_dat ('{addr: wr_addr, data: wr_data}),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   always_comb begin
      slot = SLOT_IDLE;
      if (rst)                                     slot = SLOT_IDLE;
      else if (fifo_empty)                         slot = rd_req ? SLOT_READ : SLOT_IDLE;
      else if (!rd_req || wait_cnt_q == WAIT_LAST) slot = SLOT_WRITE;
      else                                         slot = SLOT_READ;
   end

   always_comb begin
      wait_cnt_d   = (pop || fifo_empty) ? '0 : wait_cnt_q + 1'b1;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      rd_valid_d   = mem_re_q;
      overflow_d   = overflow_q | drop;
      drop_count_d = drop_count_q;
      if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      case (slot)
         SLOT_READ: begin
            mem_re_d   = 1'b1;
            mem_addr_d = rd_addr;
         end
         SLOT_WRITE: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = head_dat.addr;
            mem_wdata_d = head_dat.data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge vramclk) begin
      if (rst) begin
         wait_cnt_q   <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         rd_valid_q   <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         rd_valid_q   <= rd_valid_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Masking with rst cancels a read whose data would otherwise surface during reset.
   assign rd_gnt     = (slot == SLOT_READ);
   assign rd_valid   = rd_valid_q && !rst;
   assign rd_data    = rd_valid ? mem_rdata : '0;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign mem_re     = mem_re_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural synchronous VRAM model.
module tb_vram_arbiter;
   localparam int FIFO_DEPTH = 4;
   localparam int MAX_WAIT   = 8;

   logic        vramclk = 1'b0;
   logic        rst     = 1'b1;
   logic        wr_we   = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [1:0]  wr_data = '0;
   logic        rd_req  = 1'b0;
   logic [15:0] rd_addr = '0;
   logic        rd_gnt, rd_valid, mem_we, mem_re, overflow;
   logic [1:0]  rd_data, mem_wdata;
   logic [1:0]  mem_rdata = '0;
   logic [15:0] mem_addr;
   logic [2:0]  fifo_level;
   logic [7:0]  drop_count;

   logic [1:0] ram [0:65535];
   int checks = 0, errors = 0, cyc = 0;
   int rd_valid_cnt = 0, mem_we_cnt = 0;
   bit wr_chk_en = 1'b1;

   typedef struct { int gcyc; logic [1:0] data; } rd_exp_t;
   typedef struct { int scyc; int lat; logic [15:0] addr; logic [1:0] data; } wr_exp_t;
   rd_exp_t rdq[$];
   wr_exp_t wrq[$];

   vram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .vramclk(vramclk), .rst(rst), .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 vramclk = ~vramclk;
   always @(posedge vramclk) cyc <= cyc + 1;

   always @(posedge vramclk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   function automatic logic [1:0] pix(input int a);
      return 2'(a ^ (a >> 2) ^ (a >> 5));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Output-side monitor: pops expectations as the DUT produces reads and RAM writes.
   always @(negedge vramclk) begin
      rd_exp_t re;
      wr_exp_t we;
      if (rst) begin
         rdq.delete();
         wrq.delete();
      end
      if (!rd_req) chk("gnt_no_req", rd_gnt, 0);
      if (rd_valid) begin
         rd_valid_cnt++;
         if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            re = rdq.pop_front();
            chk("rd_data", rd_data, re.data);
            chk("rd_lat", cyc - re.gcyc, 2);
         end
      end
      if (rd_gnt) rdq.push_back('{cyc, ram[rd_addr]});
      if (mem_we) begin
         mem_we_cnt++;
         chk("we_re_excl", mem_re, 0);
         if (wr_chk_en) begin
            if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               we = wrq.pop_front();
               chk("wr_addr", mem_addr, we.addr);
               chk("wr_data", mem_wdata, we.data);
               if (we.lat != 0) chk("wr_lat", cyc - we.scyc, we.lat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge vramclk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] a, input logic [1:0] d, input bit acc, input int lat);
      wr_we   = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (acc) wrq.push_back('{cyc, lat, a, d});
      tick();
      wr_we = 1'b0;
   endtask

   task automatic drain(input bit rd_too, input int bound);
      for (int i = 0; i < bound && (wrq.size() != 0 || (rd_too && rdq.size() != 0)); i++) tick();
      chk("drain", wrq.size() + (rd_too ? rdq.size() : 0), 0);
   endtask

   initial begin
      int p, low, v0, w0;
      for (int i = 0; i < 65536; i++) ram[i] = pix(i);

      // Reset, idle outputs
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge vramclk);
         chk("rst_mem", {mem_addr, mem_wdata, mem_we, mem_re}, 0);
         chk("rst_misc", {rd_gnt, rd_valid, rd_data, fifo_level, overflow, drop_count}, 0);
         tick();
      end

      // Lone write, no reads
      strobe(16'h1234, 2'd2, 1'b1, 2);
      @(negedge vramclk);
      chk("lw_lvl1", fifo_level, 1);
      tick();
      @(negedge vramclk);
      chk("lw_we", mem_we, 1);
      chk("lw_lvl0", fifo_level, 0);
      tick();
      drain(1'b1, 20);
      chk("lw_ram", ram[16'h1234], 2);

      // Back-to-back reads 0..15
      v0 = rd_valid_cnt;
      w0 = mem_we_cnt;
      rd_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rd_addr = 16'(i);
         @(negedge vramclk);
         chk("rb_gnt", rd_gnt, 1);
         tick();
      end
      rd_req = 1'b0;
      drain(1'b1, 20);
      chk("rb_cnt", rd_valid_cnt - v0, 16);
      chk("rb_no_we", mem_we_cnt - w0, 0);

      // Starvation guard
      rd_req  = 1'b1;
      rd_addr = 16'h0040;
      tick();
      p = cyc;
      strobe(16'h0AB0, 2'd1, 1'b1, 9);
      low = -1;
      for (int i = 0; i < 20 && low < 0; i++) begin
         @(negedge vramclk);
         if (!rd_gnt) low = cyc;
         else tick();
      end
      chk("sg_gap", low - p, 8);
      tick();
      @(negedge vramclk);
      chk("sg_resume", rd_gnt, 1);
      tick();
      rd_req = 1'b0;
      drain(1'b1, 30);

      // Overflow under a sustained read burst
      rd_req  = 1'b1;
      rd_addr = 16'h0050;
      tick();
      @(negedge vramclk);
      chk("ov_pre", {overflow, drop_count}, 0);
      tick();
      for (int i = 0; i < 6; i++) strobe(16'h0100 + 16'(i), 2'(i + 1), i < 4, 0);
      @(negedge vramclk);
      chk("ov_drops", drop_count, 2);
      chk("ov_flag", overflow, 1);
      tick();
      drain(1'b0, 100);
      chk("ov_hold", drop_count, 2);

      // Saturation of drop_count
      wr_chk_en = 1'b0;
      for (int i = 0; i < 400; i++) begin
         wr_we   = 1'b1;
         wr_addr = 16'h0200 + 16'(i);
         wr_data = 2'(i);
         tick();
      end
      wr_we = 1'b0;
      @(negedge vramclk);
      chk("sat_cnt", drop_count, 255);
      chk("sat_flag", overflow, 1);
      tick();
      rd_req = 1'b0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      wr_chk_en = 1'b1;
      @(negedge vramclk);
      chk("sat_rst", {overflow, drop_count, fifo_level}, 0);
      tick();

      // Reset mid-operation: FIFO holds 3 entries, grant one cycle before rst
      rd_req  = 1'b1;
      rd_addr = 16'h0060;
      tick();
      for (int i = 0; i < 3; i++) strobe(16'h0300 + 16'(i), 2'(i), 1'b1, 0);
      @(negedge vramclk);
      chk("fl_gnt", rd_gnt, 1);
      chk("fl_lvl3", fifo_level, 3);
      tick();
      rst     = 1'b1;
      wr_we   = 1'b1;
      wr_addr = 16'h0777;
      @(negedge vramclk);
      chk("fl_gnt_rst", rd_gnt, 0);
      v0 = rd_valid_cnt;
      w0 = mem_we_cnt;
      tick();
      rst    = 1'b0;
      wr_we  = 1'b0;
      rd_req = 1'b0;
      @(negedge vramclk);
      chk("fl_lvl0", fifo_level, 0);
      repeat (20) tick();
      chk("fl_no_valid", rd_valid_cnt - v0, 0);
      chk("fl_no_we", mem_we_cnt - w0, 0);
      chk("end_queues", rdq.size() + wrq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous pixel VRAM between the video sampler's write stream and the display scanout's read requests, all in the vramclk domain. Sampler writes carry no backpressure, so they are buffered in a small FIFO. Reads have strict priority, except that a starvation guard forces a write slot. Writes lost on FIFO overflow are counted and flagged.

## Interface
Parameters:
- FIFO_DEPTH, 4: write-buffer entries; power of two, at least 2.
- MAX_WAIT, 8: maximum consecutive cycles the FIFO may be non-empty without a write slot; at least 1.

Ports:
- vramclk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_we  in  1  one-cycle write strobe from the sampler.
- wr_addr  in  16  {ypos, xpos} address, qualified by wr_we.
- wr_data  in  2  pixel shade, qualified by wr_we.
- rd_req  in  1  scanout read request; held until granted.
- rd_addr  in  16  read address, qualified by rd_req.
- rd_gnt  out  1  combinational; the request is accepted this cycle.
- rd_valid  out  1  read data valid.
- rd_data  out  2  read data; equals mem_rdata, qualified by rd_valid.
- mem_addr  out  16  registered RAM address.
- mem_wdata  out  2  registered RAM write data.
- mem_we  out  1  registered RAM write enable.
- mem_re  out  1  registered RAM read enable.
- mem_rdata  in  2  RAM read data, valid 1 cycle after mem_re.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set on the first dropped write, cleared only by rst.
- drop_count  out  8  dropped-write count, saturating at 255.

## Operation
- Slot choice is made every cycle from the current state: IDLE, READ or WRITE.
  - FIFO empty: READ if rd_req, else IDLE.
  - FIFO non-empty and (!rd_req or wait_cnt == MAX_WAIT-1): WRITE.
  - Otherwise: READ.
- READ: rd_gnt=1. Next cycle, mem_re=1, mem_we=0, mem_addr=rd_addr.
- WRITE: pop the FIFO head. Next cycle, mem_we=1, mem_re=0, mem_addr/mem_wdata = head.
- IDLE: next cycle, mem_we=mem_re=0. mem_addr and mem_wdata hold their previous values.
- mem_we and mem_re are never both 1.
- wait_cnt:
  - cleared on a WRITE slot or when the FIFO is empty;
  - otherwise increments each cycle the FIFO is non-empty;
  - width $clog2(MAX_WAIT)+1; never exceeds MAX_WAIT-1.
- Push: wr_we pushes {wr_addr, wr_data}. A pushed entry is never popped in the same cycle; earliest pop is the next cycle.
- Drop: a push when FIFO full with no pop this cycle drops the incoming write. The FIFO contents are unchanged; drop_count increments (saturating) and overflow is set.
- Full FIFO with a pop in the same cycle: the push is accepted and fifo_level is unchanged.
- Writes reach RAM in arrival order. Reads are answered in grant order.
- rd_gnt is 0 whenever rd_req=0.

## Timing
- Read latency: grant in cycle N, mem_re in N+1, rd_valid=1 in N+2 with rd_data=mem_rdata.
- Back-to-back grants give one rd_valid per cycle.
- Write latency: a write pushed in cycle N reaches mem_we no earlier than N+2. Worst case without drops: N+1+FIFO_DEPTH*MAX_WAIT.
- Reset values of all outputs are 0: mem_addr, mem_wdata, mem_we, mem_re, rd_gnt, rd_valid, rd_data, fifo_level, overflow, drop_count.
- Reset mid-operation:
  - FIFO flushed and wait_cnt cleared;
  - in-flight reads are cancelled: no rd_valid for any grant issued before rst;
  - wr_we and rd_req are ignored while rst=1.
- Sampler strobe spacing is at least 3 vramclk cycles. FIFO_DEPTH=4 with MAX_WAIT=8 therefore absorbs any read burst shorter than MAX_WAIT without drops.

## Structure
- Package dmgplus_vram_pkg holds:
  - VRAM_AW=16 and PIX_W=2;
  - the wr_entry_t struct {addr, data};
  - the slot enum {SLOT_IDLE, SLOT_READ, SLOT_WRITE}.
- One sub-module, vram_wr_fifo: synchronous FIFO with push/pop/full/empty/level and a flush driven by rst.
- Arbitration, wait_cnt, the memory-port registers and the read-valid pipeline stay in vram_arbiter.

## Test plan
- Reset, no traffic: every output is 0 for 10 cycles after rst deasserts.
- Lone write wr_addr=0x1234, wr_data=2, rd_req=0: mem_we=1 with mem_addr=0x1234, mem_wdata=2 exactly 2 cycles after the strobe; fifo_level returns to 0.
- Continuous rd_req at rd_addr 0..15 with RAM model preloaded: rd_valid on 16 consecutive cycles starting 2 cycles after the first grant, with matching data; mem_we never asserts.
- Starvation guard: rd_req held high and a single write pushed. rd_gnt drops for exactly one cycle, 8 cycles after the push (MAX_WAIT=8), and the write lands. Reads resume the following cycle.
- Overflow: rd_req held high, MAX_WAIT=8, 6 strobes pushed on consecutive cycles. Exactly 2 dropped: drop_count=2, overflow=1. The 4 surviving writes land in order; drop_count holds at 255 after 300 forced drops.
- Reset mid-operation: assert rst for one cycle one cycle after a grant, with the FIFO holding 3 entries. No rd_valid appears, no mem_we for the flushed entries, and fifo_level=0.
